// File: rtl/ele_run_ctrl.sv
// Purpose: elevator car-motion sequencer. Drives the one-hot position, door and travel timing
//          from the request processor's run mode and pending-request vector.
// Latency: every output is registered and responds 1 cycle after its qualifying input is sampled.
// Backpressure: none. Inputs are sampled every cycle; mid-travel changes wait for the floor boundary.
module ele_run_ctrl #(
  parameter int FLOOR_TICKS = 64,
  parameter int DOOR_TICKS  = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ud_mode,
  input  logic [3:0] all_req,
  input  logic       open_btn,
  input  logic       close_btn,
  output logic [3:0] position,
  output logic       door_open,
  output logic       moving,
  output logic       dir_up,
  output logic       arrive
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] FLOOR_LAST = CW'(FLOOR_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST  = CW'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pos_q, pos_d;
  logic          dir_up_q, dir_up_d;
  logic          arrive_q, arrive_d;
  logic          door_open_q, door_open_d;
  logic          moving_q, moving_d;

  logic          here;
  logic [3:0]    nxt;
  logic          travel_ok;
  logic          nxt_end;

  // Floor-relative helpers: request at this floor, the floor being approached, and whether
  // the run mode still asks to keep going the way we are already travelling.
  always_comb begin
    here      = |(all_req & pos_q);
    nxt       = dir_up_q ? {pos_q[2:0], 1'b0} : {1'b0, pos_q[3:1]};
    travel_ok = dir_up_q ? (ud_mode == 2'b01) : (ud_mode == 2'b10);
    nxt_end   = dir_up_q ? nxt[3] : nxt[0];
  end

  // Next-state logic: door requests beat travel in IDLE; travel always finishes the current floor.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    arrive_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (here || open_btn) begin
          state_d = DOOR;
        end else if (ud_mode == 2'b01 && !pos_q[3]) begin
          state_d  = MOVE;
          dir_up_d = 1'b1;
        end else if (ud_mode == 2'b10 && !pos_q[0]) begin
          state_d  = MOVE;
          dir_up_d = 1'b0;
        end
      end
      MOVE: begin
        if (cnt_q == FLOOR_LAST) begin
          pos_d    = nxt;
          arrive_d = 1'b1;
          cnt_d    = '0;
          // Stop test uses the request vector as seen on the arrival edge itself.
          if (|(all_req & nxt)) begin
            state_d = DOOR;
          end else if (travel_ok && !nxt_end) begin
            state_d = MOVE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOOR: begin
        if (open_btn || here) begin
          cnt_d = '0;
        end else if (close_btn && cnt_q != '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DOOR_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    door_open_d = (state_d == DOOR);
    moving_d    = (state_d == MOVE);
  end

  // State and output registers; reset parks the car at F1 with the door shut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pos_q       <= 4'b0001;
      dir_up_q    <= 1'b0;
      arrive_q    <= 1'b0;
      door_open_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      dir_up_q    <= dir_up_d;
      arrive_q    <= arrive_d;
      door_open_q <= door_open_d;
      moving_q    <= moving_d;
    end
  end

  assign position  = pos_q;
  assign door_open = door_open_q;
  assign moving    = moving_q;
  assign dir_up    = dir_up_q;
  assign arrive    = arrive_q;

endmodule

// File: tb/tb_ele_run_ctrl.sv
// Purpose: self-checking bench for ele_run_ctrl with a floor-number reference model.
// Latency: outputs compared every cycle on the falling edge after the model steps.
// Backpressure: none; stimulus is driven on falling edges.
module tb_ele_run_ctrl;

  localparam int FT = 4;
  localparam int DT = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ud_mode = 2'b00;
  logic [3:0] all_req = 4'b0000;
  logic       open_btn = 1'b0;
  logic       close_btn = 1'b0;
  logic [3:0] position;
  logic       door_open;
  logic       moving;
  logic       dir_up;
  logic       arrive;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: floor as an integer 1..4, phase 0=parked 1=travelling 2=door open,
  // t = ticks elapsed in the current phase.
  int m_floor;
  int m_phase;
  int m_t;
  bit m_up;
  bit m_arr;

  ele_run_ctrl #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .ud_mode(ud_mode), .all_req(all_req),
    .open_btn(open_btn), .close_btn(close_btn), .position(position),
    .door_open(door_open), .moving(moving), .dir_up(dir_up), .arrive(arrive)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_floor = 1;
    m_phase = 0;
    m_t     = 0;
    m_up    = 1'b0;
    m_arr   = 1'b0;
  endfunction

  function automatic void model_step();
    bit h;
    int nf;
    m_arr = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    h = all_req[m_floor-1];
    if (m_phase == 0) begin
      m_t = 0;
      if (h || open_btn) m_phase = 2;
      else if (ud_mode == 2'b01 && m_floor < 4) begin m_phase = 1; m_up = 1'b1; end
      else if (ud_mode == 2'b10 && m_floor > 1) begin m_phase = 1; m_up = 1'b0; end
    end else if (m_phase == 1) begin
      if (m_t == FT - 1) begin
        nf      = m_up ? m_floor + 1 : m_floor - 1;
        m_floor = nf;
        m_arr   = 1'b1;
        m_t     = 0;
        if (all_req[nf-1]) m_phase = 2;
        else if (ud_mode == (m_up ? 2'b01 : 2'b10) && nf != 1 && nf != 4) m_phase = 1;
        else m_phase = 0;
      end else begin
        m_t = m_t + 1;
      end
    end else begin
      if (open_btn || h) m_t = 0;
      else if (close_btn && m_t >= 1) begin m_phase = 0; m_t = 0; end
      else if (m_t == DT - 1) begin m_phase = 0; m_t = 0; end
      else m_t = m_t + 1;
    end
  endfunction

  // One clock: step the model on the inputs present at the edge, then compare on the falling edge.
  task automatic tick();
    logic       prev_moving;
    logic [7:0] exp_v;
    logic [7:0] act_v;
    bit         inv_ok;
    prev_moving = moving;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp_v = {4'(1 << (m_floor - 1)), (m_phase == 2), (m_phase == 1), m_up, m_arr};
    act_v = {position, door_open, moving, dir_up, arrive};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model t=%0t pos/door/mov/dir/arr got %b expected %b", $time, act_v, exp_v);
    end
    inv_ok = ($countones(position) == 1) && !(door_open && moving) && !(arrive && !prev_moving);
    n_cmp++;
    if (!inv_ok) begin
      n_bad++;
      $display("FAIL invariant t=%0t pos=%b door=%b mov=%b arr=%b prev_mov=%b required onehot/exclusive/arrive-after-move",
               $time, position, door_open, moving, arrive, prev_moving);
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({position, door_open, moving, dir_up, arrive} !== 8'b0001_0000) begin
      n_bad++;
      $display("FAIL reset_state got %b required 00010000", {position, door_open, moving, dir_up, arrive});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_travel_up();
    ud_mode = 2'b01;
    all_req = 4'b1000;
    for (int c = 1; c <= 19; c++) begin
      tick();
      if (c == 1) begin
        n_cmp++;
        if (moving !== 1'b1) begin n_bad++; $display("FAIL up_start moving got %b required 1", moving); end
      end
      if (c == 5 || c == 9 || c == 13) begin
        logic [3:0] ep;
        ep = (c == 5) ? 4'b0010 : (c == 9) ? 4'b0100 : 4'b1000;
        n_cmp++;
        if (position !== ep || arrive !== 1'b1) begin
          n_bad++;
          $display("FAIL up_arrive c=%0d pos=%b arr=%b required pos=%b arr=1", c, position, arrive, ep);
        end
      end
      if (c == 13) begin
        n_cmp++;
        if (door_open !== 1'b1) begin n_bad++; $display("FAIL f4_door got %b required 1", door_open); end
        all_req = 4'b0000;
      end
      if (c == 18 || c == 19) begin
        n_cmp++;
        if (door_open !== (c == 18)) begin
          n_bad++;
          $display("FAIL f4_close c=%0d door got %b required %b", c, door_open, (c == 18));
        end
      end
    end
  endtask

  task automatic test_illegal_dir();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (moving !== 1'b0 || position !== 4'b1000) begin
        n_bad++;
        $display("FAIL up_at_f4 mov=%b pos=%b required mov=0 pos=1000", moving, position);
      end
    end
    ud_mode = 2'b10;
    for (int c = 1; c <= 13; c++) tick();
    n_cmp++;
    if (position !== 4'b0001 || moving !== 1'b0) begin
      n_bad++;
      $display("FAIL descend pos=%b mov=%b required pos=0001 mov=0", position, moving);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (moving !== 1'b0 || position !== 4'b0001) begin
        n_bad++;
        $display("FAIL down_at_f1 mov=%b pos=%b required mov=0 pos=0001", moving, position);
      end
    end
  endtask

  task automatic test_intermediate_stop();
    ud_mode = 2'b01;
    all_req = 4'b0110;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 5) begin
        n_cmp++;
        if (position !== 4'b0010 || door_open !== 1'b1) begin
          n_bad++;
          $display("FAIL f2_stop pos=%b door=%b required pos=0010 door=1", position, door_open);
        end
        all_req = 4'b0100;
      end
      if (c == 10 || c == 11) begin
        n_cmp++;
        if (door_open !== (c == 10) || moving !== 1'b0) begin
          n_bad++;
          $display("FAIL f2_hold c=%0d door=%b mov=%b required door=%b mov=0", c, door_open, moving, (c == 10));
        end
      end
      if (c == 12) begin
        n_cmp++;
        if (moving !== 1'b1) begin n_bad++; $display("FAIL resume moving got %b required 1", moving); end
      end
      if (c == 16) begin
        n_cmp++;
        if (position !== 4'b0100 || door_open !== 1'b1) begin
          n_bad++;
          $display("FAIL f3_stop pos=%b door=%b required pos=0100 door=1", position, door_open);
        end
        all_req = 4'b0000;
        ud_mode = 2'b00;
      end
    end
    n_cmp++;
    if (door_open !== 1'b0) begin n_bad++; $display("FAIL f3_close door got %b required 0", door_open); end
  endtask

  task automatic test_door_keys();
    ud_mode = 2'b10;
    all_req = 4'b0010;
    for (int c = 1; c <= 5; c++) tick();
    n_cmp++;
    if (position !== 4'b0010 || door_open !== 1'b1) begin
      n_bad++;
      $display("FAIL f2_door pos=%b door=%b required pos=0010 door=1", position, door_open);
    end
    all_req = 4'b0000;
    ud_mode = 2'b00;
    for (int c = 6; c <= 9; c++) tick();
    open_btn = 1'b1;
    for (int c = 10; c <= 12; c++) tick();
    open_btn = 1'b0;
    for (int c = 13; c <= 18; c++) begin
      tick();
      if (c == 17 || c == 18) begin
        n_cmp++;
        if (door_open !== (c == 17)) begin
          n_bad++;
          $display("FAIL open_extend c=%0d door got %b required %b", c, door_open, (c == 17));
        end
      end
    end
    open_btn = 1'b1;
    tick();
    open_btn = 1'b0;
    tick();
    tick();
    close_btn = 1'b1;
    tick();
    n_cmp++;
    if (door_open !== 1'b0) begin n_bad++; $display("FAIL close_early door got %b required 0", door_open); end
    close_btn = 1'b0;
    open_btn  = 1'b1;
    close_btn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (door_open !== 1'b1) begin n_bad++; $display("FAIL both_keys c=%0d door got %b required 1", c, door_open); end
    end
    open_btn  = 1'b0;
    close_btn = 1'b0;
    for (int c = 1; c <= 6; c++) tick();
    n_cmp++;
    if (door_open !== 1'b0) begin n_bad++; $display("FAIL both_release door got %b required 0", door_open); end
  endtask

  task automatic test_reset_mid_move();
    ud_mode = 2'b01;
    for (int c = 1; c <= 7; c++) tick();
    n_cmp++;
    if (position !== 4'b0100 || moving !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset pos=%b mov=%b required pos=0100 mov=1", position, moving);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (position !== 4'b0001 || moving !== 1'b0 || door_open !== 1'b0 || arrive !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset pos=%b mov=%b door=%b arr=%b required 0001/0/0/0", position, moving, door_open, arrive);
    end
    model_reset();
    ud_mode = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();
    ud_mode = 2'b01;
    for (int c = 1; c <= 5; c++) tick();
    n_cmp++;
    if (position !== 4'b0010 || arrive !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset pos=%b arr=%b required pos=0010 arr=1", position, arrive);
    end
    ud_mode = 2'b00;
    for (int c = 0; c < 10; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) ud_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) all_req = all_req | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      if (door_open && $urandom_range(0, 3) != 0) all_req = all_req & ~position;
      open_btn  = ($urandom_range(0, 15) == 0);
      close_btn = ($urandom_range(0, 7) == 0);
      tick();
    end
    open_btn  = 1'b0;
    close_btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_travel_up();
    test_illegal_dir();
    test_intermediate_stop();
    test_door_keys();
    test_reset_mid_move();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
